// File: rtl/mem_port_arbiter.sv
// Two-requester (DMA / core-control) arbiter for a single-port memory.
// Round-robin grant, bounded bursts, registered read-valid routing.
module mem_port_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              arb_clk,
    input  logic              arb_reset,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_last,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic              dma_rvalid,
    input  logic              core_req,
    input  logic              core_we,
    input  logic              core_last,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_ack,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] arb_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              arb_timeout,
    output logic              arb_abort
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {StIdle, StGntDma, StGntCore} state_e;

    state_e            state_q, state_d;
    logic              last_dma_q, last_dma_d;  // 1: DMA was served last
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              dma_rvalid_q, core_rvalid_q;
    logic              timeout_q, timeout_d;
    logic              abort_q, abort_d;

    logic              owner_is_dma;
    logic              own_req, own_we, own_last, other_req;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              beat, rel;

    assign owner_is_dma = (state_q == StGntDma);
    assign own_req      = owner_is_dma ? dma_req   : core_req;
    assign own_we       = owner_is_dma ? dma_we    : core_we;
    assign own_last     = owner_is_dma ? dma_last  : core_last;
    assign own_addr     = owner_is_dma ? dma_addr  : core_addr;
    assign own_wdata    = owner_is_dma ? dma_wdata : core_wdata;
    assign other_req    = owner_is_dma ? core_req  : dma_req;

    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
        beat_cnt_d = beat_cnt_q;
        timeout_d  = 1'b0;
        abort_d    = 1'b0;
        beat       = 1'b0;
        rel        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dma_req && core_req) begin
                    state_d = last_dma_q ? StGntCore : StGntDma;
                end else if (dma_req) begin
                    state_d = StGntDma;
                end else if (core_req) begin
                    state_d = StGntCore;
                end
            end
            StGntDma, StGntCore: begin
                if (!own_req) begin
                    rel     = 1'b1;
                    abort_d = 1'b1;
                end else begin
                    beat       = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (own_last) begin
                        rel = 1'b1;
                    end else if (beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        rel       = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
                // Clearing here also covers the direct hand-over to the other requester.
                if (rel) begin
                    last_dma_d = owner_is_dma;
                    beat_cnt_d = '0;
                    if (other_req) begin
                        state_d = owner_is_dma ? StGntCore : StGntDma;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge arb_clk) begin
        if (arb_reset) begin
            state_q       <= StIdle;
            last_dma_q    <= 1'b0;
            beat_cnt_q    <= '0;
            dma_rvalid_q  <= 1'b0;
            core_rvalid_q <= 1'b0;
            timeout_q     <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_dma_q    <= last_dma_d;
            beat_cnt_q    <= beat_cnt_d;
            dma_rvalid_q  <= beat && !own_we && owner_is_dma;
            core_rvalid_q <= beat && !own_we && !owner_is_dma;
            timeout_q     <= timeout_d;
            abort_q       <= abort_d;
        end
    end

    assign dma_gnt     = (state_q == StGntDma);
    assign core_gnt    = (state_q == StGntCore);
    assign dma_ack     = beat && owner_is_dma;
    assign core_ack    = beat && !owner_is_dma;
    assign dma_rvalid  = dma_rvalid_q;
    assign core_rvalid = core_rvalid_q;
    assign arb_timeout = timeout_q;
    assign arb_abort   = abort_q;

    // Memory returns read data one cycle after the enable, i.e. in the rvalid cycle.
    assign arb_rdata   = (dma_rvalid_q || core_rvalid_q) ? mem_rdata : '0;

    assign mem_en    = beat;
    assign mem_we    = beat && own_we;
    assign mem_addr  = beat ? own_addr  : '0;
    assign mem_wdata = beat ? own_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// of ownership, burst length, release reasons and read returns.
module tb_mem_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned MB = 16;

    logic          arb_clk = 1'b0;
    logic          arb_reset;
    logic          dma_req, dma_we, dma_last;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_gnt, dma_ack, dma_rvalid;
    logic          core_req, core_we, core_last;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt, core_ack, core_rvalid;
    logic [DW-1:0] arb_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          arb_timeout, arb_abort;

    always #5 arb_clk = ~arb_clk;

    mem_port_arbiter #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .MAX_BURST(MB)
    ) dut (
        .arb_clk    (arb_clk),
        .arb_reset  (arb_reset),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_last   (dma_last),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_ack    (dma_ack),
        .dma_rvalid (dma_rvalid),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_last  (core_last),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_ack   (core_ack),
        .core_rvalid(core_rvalid),
        .arb_rdata  (arb_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .arb_timeout(arb_timeout),
        .arb_abort  (arb_abort)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: owner 0 = nobody, 1 = DMA, 2 = core.
    int            m_owner;
    bit            m_last_dma;
    int            m_beats;
    bit            m_rv_dma, m_rv_core, m_to, m_ab;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] mmem [64];
    logic [DW-1:0] smem [64];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_dma(input bit r, input bit w, input bit l, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        dma_req = r; dma_we = w; dma_last = l; dma_addr = a; dma_wdata = d;
    endtask

    task automatic set_core(input bit r, input bit w, input bit l, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        core_req = r; core_we = w; core_last = l; core_addr = a; core_wdata = d;
    endtask

    task automatic model_reset();
        m_owner = 0; m_last_dma = 0; m_beats = 0;
        m_rv_dma = 0; m_rv_core = 0; m_to = 0; m_ab = 0; m_rd = '0;
    endtask

    // Called just after a rising edge with inputs driven; checks mid-cycle, then advances.
    task automatic step();
        bit            oreq, owe, olast, oth, beat, rel;
        logic [AW-1:0] oaddr;
        logic [DW-1:0] owd, rd_next;
        #4;
        oreq  = (m_owner == 1) ? dma_req   : (m_owner == 2) ? core_req : 1'b0;
        owe   = (m_owner == 1) ? dma_we    : core_we;
        olast = (m_owner == 1) ? dma_last  : core_last;
        oaddr = (m_owner == 1) ? dma_addr  : core_addr;
        owd   = (m_owner == 1) ? dma_wdata : core_wdata;
        oth   = (m_owner == 1) ? core_req  : dma_req;
        beat  = oreq;

        chk("gnt",    {dma_gnt, core_gnt}, {m_owner == 1, m_owner == 2});
        chk("ack",    {dma_ack, core_ack}, {beat && m_owner == 1, beat && m_owner == 2});
        chk("rvalid", {dma_rvalid, core_rvalid}, {m_rv_dma, m_rv_core});
        chk("rdata",  arb_rdata, (m_rv_dma || m_rv_core) ? m_rd : '0);
        chk("mem",    {mem_en, mem_we, mem_addr, mem_wdata},
            beat ? {1'b1, owe, oaddr, owd} : 40'h0);
        chk("pulse",  {arb_timeout, arb_abort}, {m_to, m_ab});

        // Memory stub follows whatever the DUT actually drives.
        rd_next = smem[mem_addr];
        if (mem_en && mem_we) smem[mem_addr] = mem_wdata;

        if (beat && !owe) m_rd = mmem[oaddr];
        if (beat && owe) mmem[oaddr] = owd;

        if (arb_reset) begin
            model_reset();
        end else begin
            m_rv_dma  = beat && !owe && m_owner == 1;
            m_rv_core = beat && !owe && m_owner == 2;
            m_to = 0; m_ab = 0; rel = 0;
            if (m_owner == 0) begin
                if (dma_req && core_req) m_owner = m_last_dma ? 2 : 1;
                else if (dma_req)        m_owner = 1;
                else if (core_req)       m_owner = 2;
            end else if (!oreq) begin
                m_ab = 1; rel = 1;
            end else begin
                m_beats++;
                if (olast) rel = 1;
                else if (m_beats == MB) begin m_to = 1; rel = 1; end
            end
            if (rel) begin
                m_last_dma = (m_owner == 1);
                m_owner    = oth ? 3 - m_owner : 0;
                m_beats    = 0;
            end
        end
        @(posedge arb_clk);
        #1;
        mem_rdata = rd_next;
    endtask

    initial begin
        int lp;
        for (int i = 0; i < 64; i++) begin
            mmem[i] = $urandom;
            smem[i] = mmem[i];
        end
        mmem[5] = 32'hDEAD_BEEF;
        smem[5] = 32'hDEAD_BEEF;
        set_dma(0, 0, 0, '0, '0);
        set_core(0, 0, 0, '0, '0);
        mem_rdata = '0;
        arb_reset = 1'b1;
        model_reset();
        @(posedge arb_clk);
        #1;
        step();
        arb_reset = 1'b0;

        // Both request after reset: DMA first, 3 writes, then direct hand-over to core read.
        set_dma(1, 1, 0, 6'd0, 32'h1000);
        set_core(1, 0, 1, 6'd5, '0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_dma(1, 1, i == 2, AW'(i), 32'h1000 + DW'(i));
            step();
        end
        set_dma(0, 0, 0, '0, '0);
        step();
        set_core(0, 0, 0, '0, '0);
        step();
        step();

        // DMA holds req for 20 beats without last.
        for (int i = 0; i < 22; i++) begin
            set_dma(1, $urandom_range(0, 1), 0, AW'($urandom), $urandom);
            step();
        end
        set_dma(0, 0, 0, '0, '0);
        step();
        step();

        // Core drops req after two beats.
        for (int i = 0; i < 3; i++) begin
            set_core(1, 1, 0, AW'(i + 10), $urandom);
            step();
        end
        set_core(0, 1, 0, 6'd20, 32'h5555_5555);
        step();
        step();

        // Reset in the middle of a DMA read burst, both requesting afterwards.
        for (int i = 0; i < 3; i++) begin
            set_dma(1, 0, 0, AW'(i + 3), '0);
            step();
        end
        set_core(1, 0, 0, 6'd5, '0);
        arb_reset = 1'b1;
        step();
        arb_reset = 1'b0;
        step();
        step();

        // Core inputs toggle while DMA owns the port.
        set_core(0, 0, 0, '0, '0);
        set_dma(0, 0, 0, '0, '0);
        step();
        step();
        set_dma(1, 1, 0, 6'd40, 32'hAAAA_0000);
        step();
        for (int i = 0; i < 10; i++) begin
            set_dma(1, $urandom_range(0, 1), 0, AW'($urandom), $urandom);
            set_core($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                     AW'($urandom), $urandom);
            if (i == 9) dma_last = 1'b1;
            step();
        end

        // Random traffic with alternating short and long burst phases.
        lp = 20;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) lp = (lp == 20) ? 2 : 20;
            set_dma($urandom_range(0, 99) < 80, $urandom_range(0, 1),
                    $urandom_range(0, 99) < lp, AW'($urandom), $urandom);
            set_core($urandom_range(0, 99) < 80, $urandom_range(0, 1),
                     $urandom_range(0, 99) < lp, AW'($urandom), $urandom);
            arb_reset = ($urandom_range(0, 299) == 0);
            step();
        end
        arb_reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have these parameters, one per line:
- DATA_W, 32, data word width
- ADDR_W, 6, memory address width (64 entries)
- MAX_BURST, 16, maximum beats per grant
REQ-002 The block SHALL have these ports, one per line:
- arb_clk  in  1  single clock, all logic on rising edge
- arb_reset  in  1  synchronous, active-high reset
- dma_req  in  1  DMA requester beat request
- dma_we  in  1  DMA beat is a write
- dma_last  in  1  DMA final beat of burst
- dma_addr  in  ADDR_W  DMA beat address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA owns the memory port
- dma_ack  out  1  DMA beat accepted this cycle
- dma_rvalid  out  1  DMA read data valid on arb_rdata
- core_req, core_we, core_last, core_addr, core_wdata  in  1/1/1/ADDR_W/DATA_W  core-control requester, same meaning as the DMA inputs
- core_gnt, core_ack, core_rvalid  out  1  core-control counterparts of the DMA outputs
- arb_rdata  out  DATA_W  read data, shared by both requesters
- mem_en, mem_we  out  1  memory port enable / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid 1 cycle after a read enable
- arb_timeout  out  1  one-cycle pulse on forced release at MAX_BURST
- arb_abort  out  1  one-cycle pulse when an owner drops req without last

Function
REQ-003 The FSM SHALL have the states IDLE, GNT_DMA and GNT_CORE; dma_gnt = (state==GNT_DMA) and core_gnt = (state==GNT_CORE), both registered.
REQ-004 In IDLE with exactly one req high, the FSM SHALL enter that requester's GNT state on the next edge; there is no memory access in the IDLE cycle.
REQ-005 In IDLE with both reqs high, the grant SHALL go to the requester that was not served last (round-robin pointer); after reset the pointer SHALL favour DMA.
REQ-006 In a GNT state a beat SHALL occur in every cycle the owner's req is high: combinationally mem_en=1, mem_we/mem_addr/mem_wdata = owner's inputs, owner ack=1.
REQ-007 The non-owner's ack SHALL be 0 and the non-owner's inputs SHALL NOT affect the mem_* outputs.
REQ-008 When not in a beat, mem_en and mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-009 A read beat SHALL cause owner rvalid=1 on the next cycle, with arb_rdata = mem_rdata; rvalid SHALL follow the requester that issued the read even if the grant has changed.
REQ-010 A beat counter SHALL clear on entry to a GNT state and increment on each beat.
REQ-011 A beat with last=1 SHALL release the grant. If the other requester's req is high in that cycle, the FSM SHALL go directly to the other GNT state (zero idle cycles); otherwise it SHALL go to IDLE.
REQ-012 The MAX_BURST-th beat without last SHALL be acked and SHALL force a release, with the same next-state rule as REQ-011, and SHALL pulse arb_timeout on the next cycle.
REQ-013 If the owner's req is low while granted, the FSM SHALL release (same next-state rule as REQ-011) and SHALL pulse arb_abort on the next cycle; there SHALL be no beat in that cycle.
REQ-014 The round-robin pointer SHALL update to the owner on every release.
REQ-015 If last and MAX_BURST occur on the same beat, the block SHALL treat it as a normal last release and SHALL NOT pulse arb_timeout.

Reset
REQ-016 While arb_reset=1 at a rising edge, the FSM SHALL go to IDLE, the beat counter SHALL clear and the pointer SHALL favour DMA.
REQ-017 Reset SHALL force all registered outputs to 0: both gnt, both rvalid, arb_rdata, arb_timeout and arb_abort.
REQ-018 Reset asserted mid-burst SHALL drop the grant on the next edge, and no rvalid SHALL be issued for a read beat made in the reset cycle.

Verification
REQ-019 Both reqs high in IDLE after reset -> dma_gnt=1 at cycle 1. DMA does 3 writes to addr 0..2, last on the 3rd beat -> core_gnt=1 the next cycle with no IDLE gap.
REQ-020 Core single read of addr 5 holding 0xDEADBEEF -> core_ack=1 in the beat cycle, then core_rvalid=1 with arb_rdata=0xDEADBEEF the next cycle, and dma_rvalid stays 0.
REQ-021 DMA req held for 20 beats with no last -> 16 acks, then arb_timeout=1 for one cycle, then the grant goes to IDLE or to core.
REQ-022 Core drops req at beat 2 with no last -> arb_abort pulse, then the FSM is in IDLE; no mem_en in the drop cycle.
REQ-023 arb_reset=1 during a DMA burst -> all outputs are 0 the next cycle. On release of reset with both requesting -> DMA is granted first.
REQ-024 Core inputs toggled while DMA owns the port -> mem_* track only the DMA inputs, and core_ack=0 throughout.
